// File: rtl/tl_pkg.sv
// -----------------------------------------------------------------------------
// tl_pkg
// Shared definitions for the two-street traffic-light controller with a
// pedestrian all-red phase.
//   tl_state_e : FSM state codes (also driven out on the debug state port)
//   L_*        : 2-bit lamp codes used on La / Lb
//   light_a / light_b / walk_on : Moore decode of a state into lamp outputs
//   last_tick  : converts a phase length in cycles into the timer value seen
//                on the last cycle of that phase
// -----------------------------------------------------------------------------
package tl_pkg;

    typedef enum logic [2:0] {
        S_AG     = 3'd0,   // A green,  B red
        S_AY     = 3'd1,   // A yellow, B red
        S_BG     = 3'd2,   // A red,    B green
        S_BY     = 3'd3,   // A red,    B yellow
        S_ALLRED = 3'd4    // both red, pedestrians walk
    } tl_state_e;

    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_RED    = 2'b10;

    // Phase timer saturates here instead of wrapping.
    localparam logic [7:0] TIMER_MAX = 8'hFF;

    // Street A lamp for a given state.
    function automatic logic [1:0] light_a(input tl_state_e s);
        logic [1:0] l;
        case (s)
            S_AG:    l = L_GREEN;
            S_AY:    l = L_YELLOW;
            default: l = L_RED;
        endcase
        return l;
    endfunction

    // Street B lamp for a given state.
    function automatic logic [1:0] light_b(input tl_state_e s);
        logic [1:0] l;
        case (s)
            S_BG:    l = L_GREEN;
            S_BY:    l = L_YELLOW;
            default: l = L_RED;
        endcase
        return l;
    endfunction

    // Walk indication is only lit during the all-red phase.
    function automatic logic walk_on(input tl_state_e s);
        logic w;
        case (s)
            S_ALLRED: w = 1'b1;
            default:  w = 1'b0;
        endcase
        return w;
    endfunction

    // Timer value on the final cycle of a phase lasting len cycles
    // (timer reads 0 on the first cycle of every phase).
    function automatic logic [7:0] last_tick(input int len);
        return 8'(len - 1);
    endfunction

endpackage

// File: rtl/tl_cntr_param_if.sv
// -----------------------------------------------------------------------------
// tl_cntr_param_if
// Sensor/lamp bundle between the traffic-light controller and its environment.
//   Ta, Tb     : street A / B traffic present (environment -> controller)
//   ped_req    : pedestrian request, level or one-cycle pulse
//   La, Lb     : lamp codes for street A / B (controller -> environment)
//   ped_walk   : walk lamp, high during the all-red phase
//   state      : current FSM state code, debug only
// Modports: master = environment side, slave = controller side.
// -----------------------------------------------------------------------------
interface tl_cntr_param_if;

    logic       Ta;
    logic       Tb;
    logic       ped_req;
    logic [1:0] La;
    logic [1:0] Lb;
    logic       ped_walk;
    logic [2:0] state;

    modport master (
        output Ta,
        output Tb,
        output ped_req,
        input  La,
        input  Lb,
        input  ped_walk,
        input  state
    );

    modport slave (
        input  Ta,
        input  Tb,
        input  ped_req,
        output La,
        output Lb,
        output ped_walk,
        output state
    );

endinterface

// File: rtl/tl_ns_logic_p.sv
// -----------------------------------------------------------------------------
// tl_ns_logic_p
// Purely combinational next-state function of the traffic-light FSM.
//   state      : current state register
//   timer      : cycles spent in the current state (0 on the first cycle)
//   Ta, Tb     : traffic sensors
//   ped_pend   : registered pedestrian request
//   direction  : 0 = all-red entered from S_AY (resume on B), 1 = from S_BY
//   next_state : state to load on the coming clock edge
// Greens end only once the minimum length has elapsed, and then only if
// their own street is empty or a pedestrian is waiting. Yellow and all-red
// phases have fixed lengths. ped_pend is the registered flag, so a request
// arriving on a yellow-exit cycle cannot divert that exit.
// -----------------------------------------------------------------------------
module tl_ns_logic_p
    import tl_pkg::*;
#(
    parameter int MIN_GREEN = 4,
    parameter int YELLOW    = 2,
    parameter int ALLRED    = 3
) (
    input  tl_state_e  state,
    input  logic [7:0] timer,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       ped_pend,
    input  logic       direction,
    output tl_state_e  next_state
);

    localparam logic [7:0] GREEN_LAST  = last_tick(MIN_GREEN);
    localparam logic [7:0] YELLOW_LAST = last_tick(YELLOW);
    localparam logic [7:0] ALLRED_LAST = last_tick(ALLRED);

    logic green_done_s;
    logic yellow_done_s;
    logic allred_done_s;

    // Phase-length comparisons; >= keeps a saturated timer from stalling.
    always_comb begin
        green_done_s  = (timer >= GREEN_LAST)  ? 1'b1 : 1'b0;
        yellow_done_s = (timer >= YELLOW_LAST) ? 1'b1 : 1'b0;
        allred_done_s = (timer >= ALLRED_LAST) ? 1'b1 : 1'b0;
    end

    // Transition table.
    always_comb begin
        next_state = state;
        case (state)
            S_AG: begin
                if (green_done_s && (!Ta || ped_pend)) begin
                    next_state = S_AY;
                end else begin
                    next_state = S_AG;
                end
            end
            S_AY: begin
                if (yellow_done_s) begin
                    if (ped_pend) begin
                        next_state = S_ALLRED;
                    end else begin
                        next_state = S_BG;
                    end
                end else begin
                    next_state = S_AY;
                end
            end
            S_BG: begin
                if (green_done_s && (!Tb || ped_pend)) begin
                    next_state = S_BY;
                end else begin
                    next_state = S_BG;
                end
            end
            S_BY: begin
                if (yellow_done_s) begin
                    if (ped_pend) begin
                        next_state = S_ALLRED;
                    end else begin
                        next_state = S_AG;
                    end
                end else begin
                    next_state = S_BY;
                end
            end
            S_ALLRED: begin
                if (allred_done_s) begin
                    if (direction) begin
                        next_state = S_AG;
                    end else begin
                        next_state = S_BG;
                    end
                end else begin
                    next_state = S_ALLRED;
                end
            end
            default: begin
                next_state = S_AG;
            end
        endcase
    end

endmodule

// File: rtl/tl_cntr_param.sv
// -----------------------------------------------------------------------------
// tl_cntr_param
// Two-street traffic-light controller with a pedestrian all-red phase.
// Parameters (cycles, legal 1..255): MIN_GREEN, YELLOW, ALLRED.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : tl_cntr_param_if.slave (Ta, Tb, ped_req in; La, Lb,
//             ped_walk, state out)
// Holds the state register, the 8-bit saturating phase timer, the pending
// pedestrian flag and the all-red direction bit; next state comes from
// tl_ns_logic_p. Lamp outputs are registered copies of the decode of the
// state being loaded, so they always equal the decode of the state register.
// The first clock edge after reset release only arms the controller: it
// keeps S_AG with the timer at 0, so the minimum green is counted from
// that edge rather than from the partial period before it.
// -----------------------------------------------------------------------------
module tl_cntr_param
    import tl_pkg::*;
#(
    parameter int MIN_GREEN = 4,
    parameter int YELLOW    = 2,
    parameter int ALLRED    = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    tl_cntr_param_if.slave  bus
);

    tl_state_e  state_r;
    tl_state_e  ns_logic_s;
    tl_state_e  next_state_s;
    logic [7:0] timer_r;
    logic       ped_pend_r;
    logic       direction_r;
    logic       run_r;
    logic [1:0] la_r;
    logic [1:0] lb_r;
    logic       walk_r;
    logic       state_change_s;
    logic       allred_entry_s;
    logic       allred_exit_s;

    tl_ns_logic_p #(
        .MIN_GREEN (MIN_GREEN),
        .YELLOW    (YELLOW),
        .ALLRED    (ALLRED)
    ) u_ns (
        .state      (state_r),
        .timer      (timer_r),
        .Ta         (bus.Ta),
        .Tb         (bus.Tb),
        .ped_pend   (ped_pend_r),
        .direction  (direction_r),
        .next_state (ns_logic_s)
    );

    // Hold S_AG on the arming edge, otherwise follow the next-state logic.
    always_comb begin
        next_state_s = S_AG;
        if (run_r) begin
            next_state_s = ns_logic_s;
        end else begin
            next_state_s = S_AG;
        end
    end

    // Edge qualifiers for the timer, pedestrian and direction registers.
    always_comb begin
        state_change_s = (next_state_s != state_r) ? 1'b1 : 1'b0;
        allred_entry_s = ((state_r != S_ALLRED) && (next_state_s == S_ALLRED)) ? 1'b1 : 1'b0;
        allred_exit_s  = ((state_r == S_ALLRED) && (next_state_s != S_ALLRED)) ? 1'b1 : 1'b0;
    end

    // Arming flag: clear in reset, set by the first edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // State register and registered Moore lamp outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_AG;
            la_r    <= L_GREEN;
            lb_r    <= L_RED;
            walk_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            la_r    <= light_a(next_state_s);
            lb_r    <= light_b(next_state_s);
            walk_r  <= walk_on(next_state_s);
        end
    end

    // Phase timer: zero on arming and on every state change, else saturating count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_r <= 8'd0;
        end else if (!run_r || state_change_s) begin
            timer_r <= 8'd0;
        end else if (timer_r != TIMER_MAX) begin
            timer_r <= timer_r + 8'd1;
        end else begin
            timer_r <= timer_r;
        end
    end

    // Pending pedestrian flag: requests inside the all-red phase are ignored;
    // the flag drops on the edge that leaves the all-red phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ped_pend_r <= 1'b0;
        end else if (state_r == S_ALLRED) begin
            if (allred_exit_s) begin
                ped_pend_r <= 1'b0;
            end else begin
                ped_pend_r <= ped_pend_r;
            end
        end else if (bus.ped_req) begin
            ped_pend_r <= 1'b1;
        end else begin
            ped_pend_r <= ped_pend_r;
        end
    end

    // Direction bit: remembers which yellow led into the all-red phase
    // (1 = from S_BY, so traffic resumes on A).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            direction_r <= 1'b0;
        end else if (allred_entry_s) begin
            direction_r <= (state_r == S_BY) ? 1'b1 : 1'b0;
        end else begin
            direction_r <= direction_r;
        end
    end

    assign bus.La       = la_r;
    assign bus.Lb       = lb_r;
    assign bus.ped_walk = walk_r;
    assign bus.state    = state_r;

endmodule

// File: tb/tb_tl_cntr_param.sv
// -----------------------------------------------------------------------------
// tb_tl_cntr_param
// Self-checking bench for tl_cntr_param. Cycle n is the clock period that
// starts at the n-th rising edge after reset release; inputs for cycle n are
// applied before edge n and outputs are sampled 1 time unit after edge n.
// dut_d uses default parameters, dut_m uses MIN_GREEN=YELLOW=ALLRED=1 with
// both sensors tied low.
// -----------------------------------------------------------------------------
module tb_tl_cntr_param;

    logic clk;
    logic reset_n;

    tl_cntr_param_if if_d ();
    tl_cntr_param_if if_m ();

    tl_cntr_param dut_d (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_d.slave)
    );

    tl_cntr_param #(
        .MIN_GREEN (1),
        .YELLOW    (1),
        .ALLRED    (1)
    ) dut_m (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if_m.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         ta;
        bit         tb;
        bit         pr;
        logic [1:0] la;
        logic [1:0] lb;
        bit         walk;
        logic [2:0] st;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    localparam logic [1:0] G = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] R = 2'b10;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void add_rows(input int n, input bit rst, input bit ta, input bit tb,
                                     input bit pr, input logic [1:0] la, input logic [1:0] lb,
                                     input bit walk, input logic [2:0] st);
        for (int k = 0; k < n; k++) begin
            vec_t v;
            v.rst  = (k == 0) ? rst : 1'b0;
            v.ta   = ta;
            v.tb   = tb;
            v.pr   = pr;
            v.la   = la;
            v.lb   = lb;
            v.walk = walk;
            v.st   = st;
            vecs.push_back(v);
        end
    endfunction

    task automatic set_in(input bit ta, input bit tb, input bit pr);
        if_d.Ta      = ta;
        if_d.Tb      = tb;
        if_d.ped_req = pr;
    endtask

    // Reset both DUTs, check reset outputs, release at a falling edge.
    task automatic apply_reset();
        reset_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("rst_La", {6'd0, if_d.La}, {6'd0, G});
        chk("rst_Lb", {6'd0, if_d.Lb}, {6'd0, R});
        chk("rst_walk", {7'd0, if_d.ped_walk}, 8'd0);
        chk("rst_state", {5'd0, if_d.state}, 8'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         walk_cnt;
        logic [2:0] exp_st;
        logic [1:0] exp_la;

        n_checks     = 0;
        n_fail       = 0;
        reset_n      = 1'b0;
        set_in(1'b0, 1'b0, 1'b0);
        if_m.Ta      = 1'b0;
        if_m.Tb      = 1'b0;
        if_m.ped_req = 1'b0;

        // Ta=0, Tb=1: A green 1-4, yellow 5-6, B green from 7 and held.
        add_rows(4, 1'b1, 1'b0, 1'b1, 1'b0, G, R, 1'b0, 3'd0);
        add_rows(2, 1'b0, 1'b0, 1'b1, 1'b0, Y, R, 1'b0, 3'd1);
        add_rows(4, 1'b0, 1'b0, 1'b1, 1'b0, R, G, 1'b0, 3'd2);
        // Ta=1, ped pulse sampled at edge 10: yellow 11-12, walk 13-15, B green 16.
        add_rows(9, 1'b1, 1'b1, 1'b0, 1'b0, G, R, 1'b0, 3'd0);
        add_rows(1, 1'b0, 1'b1, 1'b0, 1'b1, G, R, 1'b0, 3'd0);
        add_rows(2, 1'b0, 1'b1, 1'b0, 1'b0, Y, R, 1'b0, 3'd1);
        add_rows(3, 1'b0, 1'b1, 1'b0, 1'b0, R, R, 1'b1, 3'd4);
        add_rows(4, 1'b0, 1'b1, 1'b0, 1'b0, R, G, 1'b0, 3'd2);
        add_rows(1, 1'b0, 1'b1, 1'b0, 1'b0, R, Y, 1'b0, 3'd3);
        // Request on the A-yellow exit edge: no diversion, B green keeps its
        // minimum, walk after B yellow, then back to A green.
        add_rows(4, 1'b1, 1'b0, 1'b1, 1'b0, G, R, 1'b0, 3'd0);
        add_rows(2, 1'b0, 1'b0, 1'b1, 1'b0, Y, R, 1'b0, 3'd1);
        add_rows(1, 1'b0, 1'b0, 1'b1, 1'b1, R, G, 1'b0, 3'd2);
        add_rows(3, 1'b0, 1'b0, 1'b1, 1'b0, R, G, 1'b0, 3'd2);
        add_rows(2, 1'b0, 1'b0, 1'b1, 1'b0, R, Y, 1'b0, 3'd3);
        add_rows(3, 1'b0, 1'b0, 1'b1, 1'b0, R, R, 1'b1, 3'd4);
        add_rows(1, 1'b0, 1'b0, 1'b1, 1'b0, G, R, 1'b0, 3'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) begin
                apply_reset();
            end
            set_in(vecs[i].ta, vecs[i].tb, vecs[i].pr);
            step();
            chk($sformatf("vec%0d_La", i), {6'd0, if_d.La}, {6'd0, vecs[i].la});
            chk($sformatf("vec%0d_Lb", i), {6'd0, if_d.Lb}, {6'd0, vecs[i].lb});
            chk($sformatf("vec%0d_walk", i), {7'd0, if_d.ped_walk}, {7'd0, vecs[i].walk});
            chk($sformatf("vec%0d_state", i), {5'd0, if_d.state}, {5'd0, vecs[i].st});
        end

        // Ta held: A green for 50 cycles, then timer saturates at 255.
        apply_reset();
        set_in(1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 50; c++) begin
            step();
            chk($sformatf("hold_c%0d_La", c), {6'd0, if_d.La}, {6'd0, G});
            chk($sformatf("hold_c%0d_Lb", c), {6'd0, if_d.Lb}, {6'd0, R});
        end
        repeat (260) step();
        chk("timer_saturate", dut_d.timer_r, 8'hFF);
        chk("sat_state", {5'd0, if_d.state}, 8'd0);

        // ped_req held through the walk phase: exactly one walk phase.
        apply_reset();
        walk_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            set_in(1'b1, 1'b0, ((c == 5) || (c >= 9 && c <= 11)) ? 1'b1 : 1'b0);
            step();
            if (if_d.ped_walk) walk_cnt = walk_cnt + 1;
            if (c == 11) begin
                chk("walk_exit_state", {5'd0, if_d.state}, 8'd2);
                chk("walk_exit_pend", {7'd0, dut_d.ped_pend_r}, 8'd0);
            end
        end
        chk("walk_count", walk_cnt[7:0], 8'd3);

        // Asynchronous reset pulse in the middle of B yellow.
        apply_reset();
        set_in(1'b0, 1'b0, 1'b0);
        repeat (11) step();
        chk("pre_reset_state", {5'd0, if_d.state}, 8'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_La", {6'd0, if_d.La}, {6'd0, G});
        chk("async_Lb", {6'd0, if_d.Lb}, {6'd0, R});
        chk("async_state", {5'd0, if_d.state}, 8'd0);
        reset_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            chk($sformatf("post_rst_c%0d_state", c), {5'd0, if_d.state},
                (c <= 4) ? 8'd0 : 8'd1);
        end

        // Minimum parameters, no traffic: AG, AY, BG, BY every 4 cycles.
        apply_reset();
        for (int c = 1; c <= 12; c++) begin
            step();
            exp_st = 3'((c - 1) % 4);
            case (exp_st)
                3'd0:    exp_la = G;
                3'd1:    exp_la = Y;
                default: exp_la = R;
            endcase
            chk($sformatf("min_c%0d_state", c), {5'd0, if_m.state}, {5'd0, exp_st});
            chk($sformatf("min_c%0d_La", c), {6'd0, if_m.La}, {6'd0, exp_la});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
